// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump streamer: FSM encoding and
// fixed memory timing.
package mem_dump_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  // Synchronous data memory: read data arrives one cycle after the strobe.
  localparam int unsigned RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dump_streamer.sv
// Streams a contiguous window of data memory out as one word per valid/ready
// handshake, with a last marker on the final word and a done pulse at the end.
module mem_dump_streamer
  import mem_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned REM_W = ADDR_W + 1;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr, addr_next;
  logic [REM_W-1:0]  remaining, remaining_next;

  logic              mem_rd_en_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] out_data_next;
  logic              out_valid_next;
  logic              out_last_next;
  logic              busy_next;
  logic              done_next;

  logic last_word;
  assign last_word = (remaining == REM_W'(1));

  // State, counters and all outputs are registered from their next values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      mem_rd_en <= mem_rd_en_next;
      mem_addr  <= mem_addr_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    out_data_next  = out_data;
    out_last_next  = out_last;

    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_next = FIN;
          end else begin
            addr_next      = base_addr;
            remaining_next = word_count;
            state_next     = ISSUE;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        out_data_next = mem_rd_data;
        out_last_next = last_word;
        state_next    = SEND;
      end
      SEND: begin
        // Word and last flag hold until the sink takes the word.
        if (out_ready) begin
          out_last_next = 1'b0;
          if (last_word) begin
            state_next = FIN;
          end else begin
            remaining_next = remaining - REM_W'(1);
            addr_next      = addr + ADDR_W'(1);
            state_next     = ISSUE;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Output values for the cycle spent in state_next.
    mem_rd_en_next = (state_next == ISSUE);
    mem_addr_next  = (state_next == ISSUE) ? addr_next : mem_addr;
    out_valid_next = (state_next == SEND);
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == FIN);
  end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: a synchronous memory model feeds the
// DUT and a monitor logs handshakes, reads and done pulses for the test tasks.
module tb_mem_dump_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  logic [15:0] words [$];
  logic        lasts [$];
  logic [7:0]  addrs [$];
  int          done_cnt;
  int          last_viol;
  int          cyc;
  int          last_hs_cyc;
  int          done_cyc;

  mem_dump_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // One-cycle-latency data memory.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Monitor sees the values held during the cycle that ends at this edge.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (out_valid && out_ready) begin
        words.push_back(out_data);
        lasts.push_back(out_last);
        if (out_last) last_hs_cyc <= cyc;
      end
      if (mem_rd_en) addrs.push_back(mem_addr);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (out_last && !out_valid) last_viol <= last_viol + 1;
    end
  end

  task automatic clear_logs();
    words.delete();
    lasts.delete();
    addrs.delete();
    done_cnt    = 0;
    last_hs_cyc = -100;
    done_cyc    = -200;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [8:0] c);
    @(negedge clock);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
    total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_data); end
    total++; if ({out_valid, out_last, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {out_valid, out_last, busy, done});
    end
  endtask

  task automatic test_basic();
    int lat;
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'd4, 9'd3);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=busy want=idle"); end
    total++; if (words.size() !== 3) begin bad++; $display("FAIL basic_count got=%0d want=3", words.size()); end
    if (words.size() == 3) begin
      total++; if ({words[0], words[1], words[2]} !== {16'd12, 16'd15, 16'd18}) begin
        bad++; $display("FAIL basic_words got=%0d,%0d,%0d want=12,15,18", words[0], words[1], words[2]);
      end
      total++; if ({lasts[0], lasts[1], lasts[2]} !== 3'b001) begin
        bad++; $display("FAIL basic_last got=%b%b%b want=001", lasts[0], lasts[1], lasts[2]);
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc - last_hs_cyc !== 1) begin
      bad++; $display("FAIL basic_done_delay got=%0d want=1", done_cyc - last_hs_cyc);
    end
    total++; if (addrs.size() !== 3) begin bad++; $display("FAIL basic_reads got=%0d want=3", addrs.size()); end
  endtask

  task automatic test_back_pressure();
    int  guard;
    int  unstable;
    int  reads_before;
    bit  ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'd4, 9'd3);
    guard = 0;
    while (words.size() < 1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    reads_before = addrs.size();
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || out_data !== 16'd15) unstable++;
      @(negedge clock);
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d_bad_cycles want=0", unstable); end
    total++; if (addrs.size() !== reads_before) begin
      bad++; $display("FAIL bp_extra_read got=%0d want=%0d", addrs.size(), reads_before);
    end
    out_ready = 1'b1;
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=busy want=idle"); end
    total++; if (words.size() !== 3 || words[0] !== 16'd12 || words[1] !== 16'd15 || words[2] !== 16'd18) begin
      bad++; $display("FAIL bp_words got_n=%0d want=12,15,18", words.size());
    end
    total++; if (addrs.size() !== 3) begin bad++; $display("FAIL bp_reads got=%0d want=3", addrs.size()); end
  endtask

  task automatic test_wrap_full();
    bit ok;
    int nlast;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'd254, 9'd4);
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=busy want=idle"); end
    total++; if (addrs.size() !== 4 || addrs[0] !== 8'd254 || addrs[1] !== 8'd255 || addrs[2] !== 8'd0 || addrs[3] !== 8'd1) begin
      bad++; $display("FAIL wrap_addrs got_n=%0d want=254,255,0,1", addrs.size());
    end
    total++; if (words.size() !== 4 || words[0] !== 16'd762 || words[1] !== 16'd765 || words[2] !== 16'd0 || words[3] !== 16'd3) begin
      bad++; $display("FAIL wrap_words got_n=%0d want=762,765,0,3", words.size());
    end

    clear_logs();
    pulse_start(8'd0, 9'd256);
    wait_idle(256 * 3 + 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got=busy want=idle"); end
    total++; if (words.size() !== 256) begin bad++; $display("FAIL full_count got=%0d want=256", words.size()); end
    if (words.size() == 256) begin
      total++; if (words[255] !== 16'd765) begin bad++; $display("FAIL full_last_word got=%0d want=765", words[255]); end
      total++; if (words[100] !== 16'd300) begin bad++; $display("FAIL full_mid_word got=%0d want=300", words[100]); end
      nlast = 0;
      foreach (lasts[i]) if (lasts[i]) nlast++;
      total++; if (nlast !== 1 || lasts[255] !== 1'b1) begin
        bad++; $display("FAIL full_last_flag got_n=%0d want=1_on_word255", nlast);
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_zero_and_busy_start();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'd7, 9'd0);
    total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL zero_done got=done%b_valid%b want=done1_valid0", done, out_valid);
    end
    @(negedge clock);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_after got=done%b_busy%b want=done0_busy0", done, busy);
    end
    total++; if (addrs.size() !== 0 || words.size() !== 0) begin
      bad++; $display("FAIL zero_activity got=reads%0d_words%0d want=0_0", addrs.size(), words.size());
    end

    clear_logs();
    pulse_start(8'd10, 9'd3);
    repeat (2) @(negedge clock);
    pulse_start(8'd50, 9'd5);
    wait_idle(50, ok);
    repeat (6) @(negedge clock);
    total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL busy_start_timeout got=busy%b want=0", busy); end
    total++; if (words.size() !== 3 || words[0] !== 16'd30 || words[1] !== 16'd33 || words[2] !== 16'd36) begin
      bad++; $display("FAIL busy_start_words got_n=%0d want=30,33,36", words.size());
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'd20, 9'd5);
    guard = 0;
    while (words.size() < 1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    total++; if (out_data !== 16'd63) begin bad++; $display("FAIL mid_word2 got=%0d want=63", out_data); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if ({mem_rd_en, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 16'd0 || mem_addr !== 8'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=flags%b_data%0d_addr%0d want=0", {mem_rd_en, out_valid, out_last, busy, done}, out_data, mem_addr);
    end
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    total++; if (done_cnt !== 0 || words.size() !== 1) begin
      bad++; $display("FAIL mid_reset_abort got=done%0d_words%0d want=0_1", done_cnt, words.size());
    end
    clear_logs();
    pulse_start(8'd100, 9'd2);
    wait_idle(50, ok);
    total++; if (!ok || words.size() !== 2 || words[0] !== 16'd300 || words[1] !== 16'd303) begin
      bad++; $display("FAIL mid_restart got_n=%0d want=300,303", words.size());
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_restart_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    out_ready  = 1'b0;
    cyc        = 0;
    last_viol  = 0;
    clear_logs();

    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap_full();
    test_zero_and_busy_start();
    test_reset_mid();

    total++; if (last_viol !== 0) begin bad++; $display("FAIL last_without_valid got=%0d want=0", last_viol); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
